// File: rtl/decoder_n_to_m_skid_pkg.sv
// Shared constants and width helper for the decoder/encoder family.
package decoder_n_to_m_skid_pkg;

    localparam int DEFAULT_N_SEL = 3;

    // Smallest index width able to address 'value' entries (never below 1).
    function automatic int clog2_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_onehot_comb.sv
// Pure combinational binary-to-one-hot decode with out-of-range flag.
module decoder_onehot_comb #(
    parameter int N_SEL     = 3,
    parameter int M_OUTPUTS = 1 << N_SEL
) (
    input  logic [N_SEL-1:0]     din,
    output logic [M_OUTPUTS-1:0] onehot,
    output logic                 err
);

    always_comb begin
        onehot = '0;
        err    = (int'(din) >= M_OUTPUTS);
        for (int i = 0; i < M_OUTPUTS; i++) begin
            if (int'(din) == i) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_n_to_m_skid.sv
// Registered one-hot decoder with a 2-entry skid buffer and registered in_ready.
//
// state    | meaning
// st_empty | main and skid invalid
// st_one   | main valid, skid free
// st_full  | main and skid valid, in_ready low
module decoder_n_to_m_skid
    import decoder_n_to_m_skid_pkg::*;
#(
    parameter int N_SEL     = DEFAULT_N_SEL,
    parameter int M_OUTPUTS = 1 << N_SEL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SEL-1:0]     din,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [M_OUTPUTS-1:0] dout,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        st_empty = 2'd0,
        st_one   = 2'd1,
        st_full  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   in_ready_q;
    logic [M_OUTPUTS-1:0]   main_data;
    logic                   main_err;
    logic [M_OUTPUTS-1:0]   skid_data;
    logic                   skid_err;
    logic [M_OUTPUTS-1:0]   dec_data;
    logic                   dec_err;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   load_main_in;
    logic                   load_main_skid;
    logic                   load_skid;

    // Decode ahead of storage so both registers hold {onehot, err}.
    decoder_onehot_comb #(
        .N_SEL     (N_SEL),
        .M_OUTPUTS (M_OUTPUTS)
    ) u_decode (
        .din    (din),
        .onehot (dec_data),
        .err    (dec_err)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state != st_empty);
    assign dout      = main_data;
    assign out_err   = main_err;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            st_empty: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_nxt    = st_one;
                end
            end
            st_one: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = st_full;
                end else if (out_xfer) begin
                    state_nxt = st_empty;
                end
            end
            st_full: begin
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_nxt      = st_one;
                end
            end
            default: begin
                state_nxt = st_empty;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= st_empty;
            in_ready_q <= 1'b1;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Registered ready: look ahead at the next state, keeping out_ready off the ready path.
            in_ready_q <= (state_nxt != st_full);
            if (load_main_in) begin
                main_data <= dec_data;
                main_err  <= dec_err;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= dec_data;
                skid_err  <= dec_err;
            end
        end
    end

endmodule
